mc_fetch_ctrl: RTL
==================

Name: mc_fetch_ctrl

Overview:
- Multi-cycle control FSM that sequences the instruction-fetch datapath (PC, next-PC calculator, instruction memory) and the execute/memory/writeback resources of the MIPS core.
- Takes the fetched instruction word and the ALU zero flag.
- Produces per-state write enables and mux selects: PC update, IR load, npc_sel, is_jump, register file, ALU, extender and data memory.
- Replaces hard-wired single-cycle decode, so every architectural write happens in exactly one known cycle.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.
- HALT_ON_ILLEGAL, 0: 1 means an illegal opcode parks the FSM in HALT until reset; 0 means the illegal instruction is skipped (PC+4).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  advance enable; 0 freezes the FSM
- instr  in  32  instruction word from instruction memory
- alu_zero  in  1  ALU zero flag
- state  out  3  current FSM state (debug)
- pc_we  out  1  PC load strobe
- ir_we  out  1  instruction register load strobe
- npc_sel  out  1  1 selects the branch target (beq)
- is_jump  out  1  1 selects the j target
- reg_we  out  1  register file write strobe
- reg_dst  out  1  0 = rt, 1 = rd
- alu_src  out  1  0 = rt data, 1 = extended immediate
- alu_op  out  2  00 add, 01 sub, 10 or, 11 pass-B
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm16<<16
- mem_we  out  1  data memory write strobe
- mem_to_reg  out  1  1 selects data memory as the writeback source
- illegal  out  1  sticky flag: an illegal opcode was decoded
- retired  out  CNT_W  count of completed instructions

Behaviour:
- States, encoded 3 bits: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset (rst_n low, asynchronous):
  - state=FETCH.
  - All outputs 0, including illegal and retired; latched opcode/funct cleared.
  - Reset asserted mid-instruction aborts it; no strobe fires in that cycle.
- Supported instructions (opcode/funct): addu 000000/100001, subu 000000/100011, ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010. Every other opcode/funct is illegal.
- Strobe outputs (pc_we, ir_we, reg_we, mem_we) are combinational from state and latched op, high for exactly one cycle.
- Select outputs are held stable from EXEC through the end of the instruction.
- en=0:
  - State, latch and counter are held.
  - All four strobes are forced to 0.
  - Select outputs keep their values.
- FETCH: ir_we=1; next state DECODE.
- DECODE:
  - Latch instr[31:26] and instr[5:0].
  - j: pc_we=1, is_jump=1; next FETCH.
  - Illegal opcode: set illegal. If HALT_ON_ILLEGAL=0: pc_we=1 (PC+4), next FETCH. If 1: next HALT, no pc_we.
  - All other instructions: next EXEC.
- EXEC:
  - addu/subu: alu_src=0, alu_op=add or sub; next WB.
  - ori: alu_src=1, ext_op=zero-extend, alu_op=or; next WB.
  - lui: alu_src=1, ext_op=imm16<<16, alu_op=pass-B; next WB.
  - lw/sw: alu_src=1, ext_op=sign-extend, alu_op=add; next MEM.
  - beq: alu_op=sub, npc_sel=1, pc_we=1; next FETCH. The next-PC calculator uses alu_zero in the same cycle; the FSM does not sample alu_zero itself.
- MEM:
  - sw: mem_we=1, pc_we=1; next FETCH.
  - lw: next WB.
- WB:
  - reg_we=1 and pc_we=1.
  - reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw only.
  - Next FETCH.
- HALT: all strobes 0; exit only via reset.
- retired increments by 1 on every cycle with pc_we=1 (including a skipped illegal instruction) and wraps from 2^CNT_W-1 to 0.
- Cycles per instruction with en held high: j 2, illegal (skip) 2, beq 3, sw 4, addu/subu/ori/lui 4, lw 5.
- npc_sel and is_jump are never both 1.
- pc_we and ir_we are never high in the same cycle.

Decomposition:
- Package mips_pkg:
  - opcode and funct localparams;
  - state encoding;
  - alu_op and ext_op codes;
  - a struct/typedef grouping the control bundle.
- Sub-module mips_op_decoder (combinational):
  - input: opcode/funct;
  - outputs: class one-hot {rtype_add, rtype_sub, ori, lui, lw, sw, beq, j, illegal}.
  - The FSM instantiates it on the latched fields, plus a second instance on live instr for the DECODE decision.

Test Plan:
- Reset, then run addu (0x00851021), en=1 → state sequence 0,1,2,4,0; ir_we in cycle 0; reg_we=pc_we=1 and reg_dst=1 in cycle 3; retired=1.
- lw (0x8C820004) then sw (0xAC820004) → lw takes 5 cycles, with mem_to_reg=1 and reg_we in WB; sw takes 4 cycles, with mem_we=1 and pc_we=1 in MEM and no reg_we; retired=2.
- beq (0x10000003) with alu_zero=1, then with alu_zero=0 → 3 cycles each; npc_sel=pc_we=1 in EXEC both times; j (0x08000C00) → 2 cycles, is_jump=pc_we=1 in DECODE.
- Opcode 0x3F: with HALT_ON_ILLEGAL=0 → illegal=1, pc_we in DECODE, back to FETCH, retired+1. With HALT_ON_ILLEGAL=1 → state=5 held for 20 cycles with no strobes.
- en dropped to 0 for 3 cycles while in EXEC of ori → state stays 2, strobes 0, alu_op stays 10; ori completes normally once en=1.
- rst_n pulsed low asynchronously in WB of addu, mid-cycle → reg_we never asserts, state=0, retired=0, illegal=0. Separately, CNT_W=4 with 17 j instructions → retired wraps to 1.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, state encoding and control-bundle types for the multi-cycle MIPS control
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_OR    = 2'b10,
    ALU_PASSB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    EXT_ZERO = 2'b00,
    EXT_SIGN = 2'b01,
    EXT_LUI  = 2'b10
  } ext_op_e;

  // One-hot instruction class produced by the opcode decoder
  typedef struct packed {
    logic rtype_add;
    logic rtype_sub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic illegal;
  } op_class_t;

  // Datapath select bundle driven while an instruction is in flight
  typedef struct packed {
    logic    npc_sel;
    logic    is_jump;
    logic    reg_dst;
    logic    alu_src;
    alu_op_e alu_op;
    ext_op_e ext_op;
    logic    mem_to_reg;
  } ctrl_sel_t;

endpackage

// File: rtl/mips_op_decoder.sv
// rtl/mips_op_decoder.sv - combinational opcode/funct to one-hot instruction class
module mips_op_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output op_class_t  cls_o
);

  // Exactly one class bit is set; anything unrecognised lands in illegal
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADDU)      cls_o.rtype_add = 1'b1;
        else if (funct_i == FN_SUBU) cls_o.rtype_sub = 1'b1;
        else                         cls_o.illegal   = 1'b1;
      end
      OP_ORI:  cls_o.ori     = 1'b1;
      OP_LUI:  cls_o.lui     = 1'b1;
      OP_LW:   cls_o.lw      = 1'b1;
      OP_SW:   cls_o.sw      = 1'b1;
      OP_BEQ:  cls_o.beq     = 1'b1;
      OP_J:    cls_o.j       = 1'b1;
      default: cls_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_fetch_ctrl.sv
// rtl/mc_fetch_ctrl.sv - multi-cycle fetch/execute control FSM for the MIPS core
module mc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  output logic [2:0]       state,
  output logic             pc_we,
  output logic             ir_we,
  output logic             npc_sel,
  output logic             is_jump,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic             mem_we,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;
  op_class_t        live_cls, lat_cls;
  ctrl_sel_t        sel;
  logic             pc_we_raw, ir_we_raw, reg_we_raw, mem_we_raw;

  // alu_zero feeds the next-PC calculator directly; the FSM never looks at it
  logic unused_inputs;
  assign unused_inputs = ^{alu_zero, instr[25:6]};

  mips_op_decoder u_dec_live (
    .opcode_i (instr[31:26]),
    .funct_i  (instr[5:0]),
    .cls_o    (live_cls)
  );

  mips_op_decoder u_dec_lat (
    .opcode_i (opcode_q),
    .funct_i  (funct_q),
    .cls_o    (lat_cls)
  );

  // State, latched instruction fields, sticky illegal flag and retire counter; all frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else if (en) begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opcode_q <= instr[31:26];
        funct_q  <= instr[5:0];
        if (live_cls.illegal) illegal_q <= 1'b1;
      end
      if (pc_we_raw) retired_q <= retired_q + 1'b1;
    end
  end

  // Next state and unmasked per-state strobes; DECODE steers on the live word, later states on the latch
  always_comb begin
    state_d    = state_q;
    pc_we_raw  = 1'b0;
    ir_we_raw  = 1'b0;
    reg_we_raw = 1'b0;
    mem_we_raw = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_we_raw = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        if (live_cls.j) begin
          pc_we_raw = 1'b1;
          state_d   = ST_FETCH;
        end else if (live_cls.illegal) begin
          if (HALT_ON_ILLEGAL) begin
            state_d = ST_HALT;
          end else begin
            pc_we_raw = 1'b1;
            state_d   = ST_FETCH;
          end
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (lat_cls.beq) begin
          pc_we_raw = 1'b1;
          state_d   = ST_FETCH;
        end else if (lat_cls.lw || lat_cls.sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (lat_cls.sw) begin
          mem_we_raw = 1'b1;
          pc_we_raw  = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_we_raw = 1'b1;
        pc_we_raw  = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath selects: is_jump during DECODE of j, everything else held from EXEC to the end of the instruction
  always_comb begin
    sel = '0;
    if (state_q == ST_DECODE) sel.is_jump = live_cls.j;
    if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
      sel.npc_sel    = lat_cls.beq && (state_q == ST_EXEC);
      sel.reg_dst    = lat_cls.rtype_add || lat_cls.rtype_sub;
      sel.alu_src    = lat_cls.ori || lat_cls.lui || lat_cls.lw || lat_cls.sw;
      sel.mem_to_reg = lat_cls.lw;
      if (lat_cls.rtype_sub || lat_cls.beq) sel.alu_op = ALU_SUB;
      else if (lat_cls.ori)                 sel.alu_op = ALU_OR;
      else if (lat_cls.lui)                 sel.alu_op = ALU_PASSB;
      else                                  sel.alu_op = ALU_ADD;
      if (lat_cls.lw || lat_cls.sw) sel.ext_op = EXT_SIGN;
      else if (lat_cls.lui)         sel.ext_op = EXT_LUI;
      else                          sel.ext_op = EXT_ZERO;
    end
  end

  assign state      = state_q;
  assign pc_we      = en & pc_we_raw;
  assign ir_we      = en & ir_we_raw;
  assign reg_we     = en & reg_we_raw;
  assign mem_we     = en & mem_we_raw;
  assign npc_sel    = sel.npc_sel;
  assign is_jump    = sel.is_jump;
  assign reg_dst    = sel.reg_dst;
  assign alu_src    = sel.alu_src;
  assign alu_op     = sel.alu_op;
  assign ext_op     = sel.ext_op;
  assign mem_to_reg = sel.mem_to_reg;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule
